// File: rtl/apb_i2c_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : apb_i2c_tx_fifo
// Brief    : First-word-fall-through TX FIFO between the APB bridge and the
//            I2C core, with occupancy-based full/empty and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module apb_i2c_tx_fifo #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              WR_ENA,
    input  logic [DWIDTH-1:0] WRITE_DATA_ON_TX,
    input  logic              RD_ENA,
    input  logic              CLR_ERR,
    output logic [DWIDTH-1:0] DATA_OUT,
    output logic              TX_EMPTY,
    output logic              TX_FULL,
    output logic [AWIDTH:0]   LEVEL,
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    output logic              ERROR
);

    localparam logic [AWIDTH:0] c_DEPTH = {1'b1, {AWIDTH{1'b0}}};

    logic [DWIDTH-1:0] mem_q [2**AWIDTH];
    logic [AWIDTH-1:0] wp_q, wp_d;
    logic [AWIDTH-1:0] rp_q, rp_d;
    logic [AWIDTH:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              w_push;
    logic              w_pop;

    // A push into a full FIFO is still accepted when a pop frees a slot this cycle.
    assign w_pop  = RD_ENA && (cnt_q != '0);
    assign w_push = WR_ENA && ((cnt_q != c_DEPTH) || w_pop);

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (w_push) begin
            wp_d = wp_q + AWIDTH'(1);
        end
        if (w_pop) begin
            rp_d = rp_q + AWIDTH'(1);
        end
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + (AWIDTH+1)'(1);
            2'b01:   cnt_d = cnt_q - (AWIDTH+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        // A new error in the same cycle as CLR_ERR keeps the flag set.
        ovf_d = (ovf_q && !CLR_ERR) || (WR_ENA && !w_push);
        unf_d = (unf_q && !CLR_ERR) || (RD_ENA && !w_pop);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_push) begin
            mem_q[wp_q] <= WRITE_DATA_ON_TX;
        end
    end

    assign DATA_OUT  = mem_q[rp_q];
    assign TX_EMPTY  = (cnt_q == '0);
    assign TX_FULL   = (cnt_q == c_DEPTH);
    assign LEVEL     = cnt_q;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;
    assign ERROR     = ovf_q | unf_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_i2c_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_i2c_tx_fifo
// Brief    : Self-checking bench for apb_i2c_tx_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_i2c_tx_fifo;

    localparam int DWIDTH  = 32;
    localparam int AWIDTH  = 4;
    localparam int c_DEPTH = 2**AWIDTH;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              WR_ENA;
    logic [DWIDTH-1:0] WRITE_DATA_ON_TX;
    logic              RD_ENA;
    logic              CLR_ERR;
    logic [DWIDTH-1:0] DATA_OUT;
    logic              TX_EMPTY;
    logic              TX_FULL;
    logic [AWIDTH:0]   LEVEL;
    logic              OVERFLOW;
    logic              UNDERFLOW;
    logic              ERROR;

    logic [DWIDTH-1:0] mq[$];
    bit                m_ovf;
    bit                m_unf;
    int                checks = 0;
    int                errors = 0;

    apb_i2c_tx_fifo #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
        .PCLK             (PCLK),
        .PRESET           (PRESET),
        .WR_ENA           (WR_ENA),
        .WRITE_DATA_ON_TX (WRITE_DATA_ON_TX),
        .RD_ENA           (RD_ENA),
        .CLR_ERR          (CLR_ERR),
        .DATA_OUT         (DATA_OUT),
        .TX_EMPTY         (TX_EMPTY),
        .TX_FULL          (TX_FULL),
        .LEVEL            (LEVEL),
        .OVERFLOW         (OVERFLOW),
        .UNDERFLOW        (UNDERFLOW),
        .ERROR            (ERROR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".level"}, 64'(LEVEL), 64'(mq.size()));
        check_eq({tag, ".empty"}, 64'(TX_EMPTY), 64'(mq.size() == 0));
        check_eq({tag, ".full"}, 64'(TX_FULL), 64'(mq.size() == c_DEPTH));
        check_eq({tag, ".ovf"}, 64'(OVERFLOW), 64'(m_ovf));
        check_eq({tag, ".unf"}, 64'(UNDERFLOW), 64'(m_unf));
        check_eq({tag, ".err"}, 64'(ERROR), 64'(m_ovf || m_unf));
        if (mq.size() > 0) begin
            check_eq({tag, ".data"}, 64'(DATA_OUT), 64'(mq[0]));
        end
    endtask

    // One clock: drive the request, advance the model by the FIFO rules, compare.
    task automatic step(input string tag, input logic wr, input logic [DWIDTH-1:0] d,
                        input logic rd, input logic clr);
        bit pop_ok;
        bit push_ok;
        WR_ENA           = wr;
        WRITE_DATA_ON_TX = d;
        RD_ENA           = rd;
        CLR_ERR          = clr;
        pop_ok  = rd && (mq.size() > 0);
        push_ok = wr && ((mq.size() < c_DEPTH) || pop_ok);
        @(posedge PCLK);
        #1;
        if (pop_ok)  void'(mq.pop_front());
        if (push_ok) mq.push_back(d);
        m_ovf = (m_ovf && !clr) || (wr && !push_ok);
        m_unf = (m_unf && !clr) || (rd && !pop_ok);
        WR_ENA  = 1'b0;
        RD_ENA  = 1'b0;
        CLR_ERR = 1'b0;
        compare_all(tag);
    endtask

    // Asserted between edges so the asynchronous clear is visible before any clock.
    task automatic async_reset(input string tag);
        PRESET = 1'b1;
        #2;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_eq({tag, ".async_empty"}, 64'(TX_EMPTY), 64'd1);
        check_eq({tag, ".async_level"}, 64'(LEVEL), 64'd0);
        check_eq({tag, ".async_err"}, 64'(ERROR), 64'd0);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        compare_all(tag);
    endtask

    initial begin
        PRESET           = 1'b1;
        WR_ENA           = 1'b0;
        RD_ENA           = 1'b0;
        CLR_ERR          = 1'b0;
        WRITE_DATA_ON_TX = '0;
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        @(posedge PCLK);
        #1;

        async_reset("reset");
        for (int i = 0; i < 10; i++) step("idle", 1'b0, '0, 1'b0, 1'b0);

        for (int i = 1; i <= c_DEPTH; i++) step("fill", 1'b1, DWIDTH'(i), 1'b0, 1'b0);
        check_eq("fill.full", 64'(TX_FULL), 64'd1);
        check_eq("fill.level16", 64'(LEVEL), 64'd16);

        step("ovf", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check_eq("ovf.flag", 64'(OVERFLOW), 64'd1);
        step("ovf_clr", 1'b0, '0, 1'b0, 1'b1);
        check_eq("ovf.cleared", 64'(ERROR), 64'd0);

        for (int i = 1; i <= c_DEPTH; i++) begin
            check_eq("drain.order", 64'(DATA_OUT), 64'(i));
            step("drain", 1'b0, '0, 1'b1, 1'b0);
        end
        check_eq("drain.empty", 64'(TX_EMPTY), 64'd1);

        step("unf_push", 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0);
        check_eq("unf.flag", 64'(UNDERFLOW), 64'd1);
        check_eq("unf.level", 64'(LEVEL), 64'd1);
        check_eq("unf.data", 64'(DATA_OUT), 64'hA5A5_A5A5);
        step("unf_clr", 1'b0, '0, 1'b1, 1'b1);
        step("clr_idle", 1'b0, '0, 1'b0, 1'b1);

        for (int i = 0; i < c_DEPTH; i++) step("wfill", 1'b1, DWIDTH'(32'h100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step("wrap", 1'b1, DWIDTH'(32'h200 + i), 1'b1, 1'b0);
        check_eq("wrap.level", 64'(LEVEL), 64'd16);
        check_eq("wrap.noovf", 64'(OVERFLOW), 64'd0);
        for (int i = 0; i < c_DEPTH; i++) step("wdrain", 1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) step("mid", 1'b1, DWIDTH'($urandom), 1'b0, 1'b0);
        async_reset("midrst");
        step("post_rst", 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        check_eq("post_rst.first", 64'(DATA_OUT), 64'h1234_5678);

        // Alternating fill-biased and drain-biased random phases reach both limits.
        for (int p = 0; p < 12; p++) begin
            int wp = (p % 2 == 0) ? 80 : 25;
            int rp = (p % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 150; i++) begin
                step("rand", 1'($urandom_range(0, 99) < wp), DWIDTH'($urandom),
                     1'($urandom_range(0, 99) < rp), 1'($urandom_range(0, 99) < 6));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
